panxi_pc_ctrl: RTL and testbench

Pipeline control unit for the PANXI RV32 core. It gathers redirect requests from the execute stage and the interrupt controller, and stall requests from the execute stage and the bus. It then drives the single `jmp_en`/`jmp_addr`/`hold_flag` triple consumed by `panxi_pc` and the IF/ID pipeline registers. It sequences post-jump flush bubbles, defers redirects while a bus access is stalled, and implements the JTAG debug halt.

---
 rtl/panxi_pc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_panxi_pc_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/panxi_pc_ctrl.sv
// PANXI RV32 pipeline control: merges redirect/stall requests into jmp_en/jmp_addr/hold_flag,
// sequences post-jump flush bubbles and defers redirects across bus stalls. Debug halt: PANXI_DBG_HALT_EN.
`ifndef PANXI_DW
`define PANXI_DW 32
`endif
`ifndef HOLD_WIDTH
`define HOLD_WIDTH 3
`endif
`ifndef HOLD_NONE
`define HOLD_NONE 3'b000
`endif
`ifndef HOLD_PC
`define HOLD_PC 3'b001
`endif
`ifndef HOLD_IF
`define HOLD_IF 3'b010
`endif
`ifndef HOLD_ID
`define HOLD_ID 3'b011
`endif

module panxi_pc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_jtag_xi,
  input  logic                   ex_jmp_en_xi,
  input  logic [`PANXI_DW-1:0]   ex_jmp_addr_xi,
  input  logic                   ex_hold_xi,
  input  logic                   int_jmp_en_xi,
  input  logic [`PANXI_DW-1:0]   int_jmp_addr_xi,
  input  logic                   bus_hold_xi,
  input  logic                   dbg_halt_req_xi,
  output logic                   jmp_en_xo,
  output logic [`PANXI_DW-1:0]   jmp_addr_xo,
  output logic [`HOLD_WIDTH-1:0] hold_flag_xo,
  output logic                   dbg_halted_xo
);

  localparam logic [2:0] LP_FLUSH = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1
`ifdef PANXI_DBG_HALT_EN
    ,ST_HALTED = 2'd2
`endif
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_cnt;
  logic [2:0]           w_cnt_nxt;
  logic                 r_pend_vld;
  logic                 r_pend_int;
  logic [`PANXI_DW-1:0] r_pend_addr;
  logic                 w_pend_vld_nxt;
  logic                 w_pend_int_nxt;
  logic [`PANXI_DW-1:0] w_pend_addr_nxt;
  logic                 w_rst;
  logic                 w_new_vld;
  logic                 w_req_vld;
  logic                 w_tgt_int;
  logic [`PANXI_DW-1:0] w_tgt_addr;
  logic                 w_jmp;

  assign w_rst     = rst | rst_jtag_xi;
  assign w_new_vld = int_jmp_en_xi | ex_jmp_en_xi;
  assign w_req_vld = w_new_vld | r_pend_vld;

  // A fresh interrupt beats anything pending; a pending target beats a fresh execute jump.
  always_comb begin
    w_tgt_addr = ex_jmp_addr_xi;
    w_tgt_int  = 1'b0;
    if (int_jmp_en_xi) begin
      w_tgt_addr = int_jmp_addr_xi;
      w_tgt_int  = 1'b1;
    end else if (r_pend_vld) begin
      w_tgt_addr = r_pend_addr;
      w_tgt_int  = r_pend_int;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_int_nxt  = r_pend_int;
    w_pend_addr_nxt = r_pend_addr;
    w_jmp           = 1'b0;
    case (r_state)
      ST_RUN, ST_FLUSH: begin
        if (r_state == ST_FLUSH) begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
        if (w_req_vld) begin
          if (!bus_hold_xi) begin
            w_jmp          = 1'b1;
            w_pend_vld_nxt = 1'b0;
            w_cnt_nxt      = LP_FLUSH;
            w_state_nxt    = ST_FLUSH;
          end else begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_int_nxt  = w_tgt_int;
            w_pend_addr_nxt = w_tgt_addr;
          end
        end
`ifdef PANXI_DBG_HALT_EN
        else if ((r_state == ST_RUN) && dbg_halt_req_xi && !bus_hold_xi) begin
          w_state_nxt = ST_HALTED;
        end
`endif
      end
`ifdef PANXI_DBG_HALT_EN
      ST_HALTED: begin
        // Redirects seen while halted wait in the pending register until RUN resumes.
        if (w_new_vld) begin
          w_pend_vld_nxt  = 1'b1;
          w_pend_int_nxt  = w_tgt_int;
          w_pend_addr_nxt = w_tgt_addr;
        end
        if (!dbg_halt_req_xi) begin
          w_state_nxt = ST_RUN;
        end
      end
`endif
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= 3'd0;
      r_pend_vld  <= 1'b0;
      r_pend_int  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_int  <= w_pend_int_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  always_comb begin
    hold_flag_xo = `HOLD_NONE;
    if (w_rst) begin
      hold_flag_xo = `HOLD_NONE;
    end else if (bus_hold_xi) begin
      hold_flag_xo = `HOLD_PC;
    end else if (r_state != ST_RUN) begin
      hold_flag_xo = `HOLD_ID;
    end else if (ex_hold_xi) begin
      hold_flag_xo = `HOLD_ID;
    end
  end

  assign jmp_en_xo   = ~w_rst & w_jmp;
  assign jmp_addr_xo = jmp_en_xo ? w_tgt_addr : '0;

`ifdef PANXI_DBG_HALT_EN
  logic r_halted;

  // Rises one cycle into HALTED, falls together with the return to RUN.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= (r_state == ST_HALTED) && (w_state_nxt == ST_HALTED);
    end
  end

  assign dbg_halted_xo = r_halted & ~w_rst;
`else
  logic w_unused_halt_req;
  assign w_unused_halt_req = dbg_halt_req_xi;
  assign dbg_halted_xo     = 1'b0;
`endif

endmodule

// File: tb/tb_panxi_pc_ctrl.sv
// Bench for panxi_pc_ctrl (FLUSH_CYCLES=2): vector table through a scoreboard queue, plus a randomized stall sequence.
module tb_panxi_pc_ctrl;

  localparam logic [2:0] H_NONE = 3'b000;
  localparam logic [2:0] H_PC   = 3'b001;
  localparam logic [2:0] H_ID   = 3'b011;

  typedef struct {
    string       name;
    logic        rst;
    logic        jrst;
    logic        ex_en;
    logic [31:0] ex_addr;
    logic        ex_hold;
    logic        int_en;
    logic [31:0] int_addr;
    logic        bus;
    logic        halt;
    logic        e_jmp;
    logic [31:0] e_addr;
    logic [2:0]  e_hold;
    logic        e_halted;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        rst_jtag_xi;
  logic        ex_jmp_en_xi;
  logic [31:0] ex_jmp_addr_xi;
  logic        ex_hold_xi;
  logic        int_jmp_en_xi;
  logic [31:0] int_jmp_addr_xi;
  logic        bus_hold_xi;
  logic        dbg_halt_req_xi;
  logic        jmp_en_xo;
  logic [31:0] jmp_addr_xo;
  logic [2:0]  hold_flag_xo;
  logic        dbg_halted_xo;

  int   n_total;
  int   n_pass;
  vec_t vecs[$];
  vec_t exp_q[$];

  panxi_pc_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rst_jtag_xi     (rst_jtag_xi),
    .ex_jmp_en_xi    (ex_jmp_en_xi),
    .ex_jmp_addr_xi  (ex_jmp_addr_xi),
    .ex_hold_xi      (ex_hold_xi),
    .int_jmp_en_xi   (int_jmp_en_xi),
    .int_jmp_addr_xi (int_jmp_addr_xi),
    .bus_hold_xi     (bus_hold_xi),
    .dbg_halt_req_xi (dbg_halt_req_xi),
    .jmp_en_xo       (jmp_en_xo),
    .jmp_addr_xo     (jmp_addr_xo),
    .hold_flag_xo    (hold_flag_xo),
    .dbg_halted_xo   (dbg_halted_xo)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic r, input logic jr,
                              input logic ee, input logic [31:0] ea, input logic eh,
                              input logic ie, input logic [31:0] ia, input logic b,
                              input logic h, input logic ej, input logic [31:0] eaddr,
                              input logic [2:0] ehold, input logic ehalt);
    vec_t v;
    v.name = nm; v.rst = r; v.jrst = jr; v.ex_en = ee; v.ex_addr = ea; v.ex_hold = eh;
    v.int_en = ie; v.int_addr = ia; v.bus = b; v.halt = h;
    v.e_jmp = ej; v.e_addr = eaddr; v.e_hold = ehold; v.e_halted = ehalt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst; rst_jtag_xi = v.jrst;
    ex_jmp_en_xi = v.ex_en; ex_jmp_addr_xi = v.ex_addr; ex_hold_xi = v.ex_hold;
    int_jmp_en_xi = v.int_en; int_jmp_addr_xi = v.int_addr;
    bus_hold_xi = v.bus; dbg_halt_req_xi = v.halt;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".jmp_en"}, {31'd0, jmp_en_xo}, {31'd0, e.e_jmp});
      chk({e.name, ".jmp_addr"}, jmp_addr_xo, e.e_addr);
      chk({e.name, ".hold"}, {29'd0, hold_flag_xo}, {29'd0, e.e_hold});
      chk({e.name, ".halted"}, {31'd0, dbg_halted_xo}, {31'd0, e.e_halted});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        pv;
    logic        pi;
    logic [31:0] pa;
    logic        ie;
    logic        ee;
    logic [31:0] ia;
    logic [31:0] ea;

    clk = 1'b0;
    n_total = 0;
    n_pass = 0;

    //          name        rst jr ee ea          eh ie ia          b  h  ejmp eaddr       ehold  ehalt
    vecs.push_back(mk("rst_forced", 1, 0, 1, 32'h100, 1, 1, 32'h800, 1, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("idle0",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("ex_jmp",     0, 0, 1, 32'h100, 0, 0, 32'h0,   0, 0, 1, 32'h100, H_NONE, 0));
    vecs.push_back(mk("ex_fl1",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("ex_fl2",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("ex_done",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("int_prio",   0, 0, 1, 32'h100, 0, 1, 32'h800, 0, 0, 1, 32'h800, H_NONE, 0));
    vecs.push_back(mk("int_fl1",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("int_fl2",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("int_done",   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("ex_hold",    0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("bus_jmp",    0, 0, 1, 32'h200, 0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("bus_2",      0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("bus_3",      0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("bus_issue",  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h200, H_NONE, 0));
    vecs.push_back(mk("bus_fl1",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("bus_fl2",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("bus_done",   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("rep_ex",     0, 0, 1, 32'h200, 0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("rep_int",    0, 0, 0, 32'h0,   0, 1, 32'h800, 1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("rep_ex2",    0, 0, 1, 32'h300, 0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("rep_issue",  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h800, H_NONE, 0));
    vecs.push_back(mk("rep_fl1",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("rep_fl2",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("rep_done",   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("rl_jmp",     0, 0, 1, 32'h400, 0, 0, 32'h0,   0, 0, 1, 32'h400, H_NONE, 0));
    vecs.push_back(mk("rl_again",   0, 0, 1, 32'h500, 0, 0, 32'h0,   0, 0, 1, 32'h500, H_ID,   0));
    vecs.push_back(mk("rl_fl1",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("rl_fl2",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("rl_done",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("jr_jmp",     0, 0, 1, 32'h600, 0, 0, 32'h0,   0, 0, 1, 32'h600, H_NONE, 0));
    vecs.push_back(mk("jr_pend",    0, 0, 1, 32'h700, 0, 0, 32'h0,   1, 0, 0, 32'h0,   H_PC,   0));
    vecs.push_back(mk("jr_reset",   0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("jr_nostale", 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("jr_idle",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
`ifdef PANXI_DBG_HALT_EN
    vecs.push_back(mk("h_req",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("h_in",       0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("h_halted",   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   1));
    vecs.push_back(mk("h_latch",    0, 0, 1, 32'h900, 0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   1));
    vecs.push_back(mk("h_drop",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   1));
    vecs.push_back(mk("h_exit",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h900, H_NONE, 0));
    vecs.push_back(mk("h_fl1",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("h_fl2",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("h_run",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("hc_jmp",     0, 0, 1, 32'hA00, 0, 0, 32'h0,   0, 1, 1, 32'hA00, H_NONE, 0));
    vecs.push_back(mk("hc_fl1",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("hc_fl2",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("hc_req",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("hc_in",      0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("hc_halted",  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   1));
    vecs.push_back(mk("hc_rst",     1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("hc_after",   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
`else
    vecs.push_back(mk("nh_req1",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("nh_req2",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("nh_req3",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("nh_jmp",     0, 0, 1, 32'hA00, 0, 0, 32'h0,   0, 1, 1, 32'hA00, H_NONE, 0));
    vecs.push_back(mk("nh_fl1",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("nh_fl2",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_ID,   0));
    vecs.push_back(mk("nh_run",     0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,   H_NONE, 0));
    vecs.push_back(mk("nh_drop",    0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   H_NONE, 0));
`endif

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Randomized stall: redirects pile up under bus_hold; reference pending model picks the winner.
    for (int r = 0; r < 4; r++) begin
      pv = 1'b0; pi = 1'b0; pa = 32'h0;
      for (int c = 0; c < 6; c++) begin
        ie = ($urandom_range(0, 3) == 0);
        ee = ($urandom_range(0, 1) == 0);
        ia = {$urandom_range(0, 65535), 2'b00} + 32'h1000;
        ea = {$urandom_range(0, 65535), 2'b00} + 32'h2000;
        if (ie) begin
          pv = 1'b1; pi = 1'b1; pa = ia;
        end else if (ee && !pv) begin
          pv = 1'b1; pi = 1'b0; pa = ea;
        end
        apply(mk("rs_stall", 0, 0, ee, ea, 0, ie, ia, 1, 0, 0, 32'h0, H_PC, 0));
      end
      if (pv) begin
        apply(mk("rs_issue", 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, pa, H_NONE, 0));
        apply(mk("rs_fl1",   0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, H_ID, 0));
        apply(mk("rs_fl2",   0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, H_ID, 0));
      end
      apply(mk("rs_idle", 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, H_NONE, 0));
      if (pi && !pv) $display("unexpected model state");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
